mem_access_ctrl: RTL and testbench

- Initiator side of the RAM Enable/ReadWrite/MOC handshake. It sits between the control unit and the byte-addressed, big-endian data RAM.
- Accepts one CPU request (byte, half-word, word or double-word; read or write), drives the RAM strobes, and synchronises the asynchronous MOC.
- Splits a double-word into two word beats.
- Returns read data with optional sign extension, plus a one-cycle done pulse.
- Rejects misaligned or timed-out accesses with err.

---
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response and RAM-strobe bundle for mem_access_ctrl.
// slave is the controller's view; master is the CPU/RAM environment's view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              req_rw;
  logic [1:0]        req_type;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [63:0]       rdata;
  logic              mem_enable;
  logic              mem_rw;
  logic [1:0]        mem_type;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_moc;

  modport master (
    output req, req_rw, req_type, req_signed, req_addr, req_wdata,
    output mem_rdata, mem_moc,
    input  busy, done, err, rdata,
    input  mem_enable, mem_rw, mem_type, mem_addr, mem_wdata
  );

  modport slave (
    input  req, req_rw, req_type, req_signed, req_addr, req_wdata,
    input  mem_rdata, mem_moc,
    output busy, done, err, rdata,
    output mem_enable, mem_rw, mem_type, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator for the RAM Enable/ReadWrite/MOC four-phase handshake.
// Double-words go out as two big-endian word beats; reads are formatted on completion.
module mem_access_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] T_BYTE  = 2'b00;
  localparam logic [1:0] T_HALF  = 2'b01;
  localparam logic [1:0] T_WORD  = 2'b10;
  localparam logic [1:0] T_DWORD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              moc_p0, moc_p1;
  logic              moc_s;
  logic              rw_q, rw_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  logic              mrw_q, mrw_d;
  logic [1:0]        mtype_q, mtype_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [63:0]       rdata_q, rdata_d;

  function automatic logic misaligned(input logic [1:0] t, input logic [1:0] a_lo);
    case (t)
      T_HALF:          misaligned = a_lo[0];
      T_WORD, T_DWORD: misaligned = (a_lo != 2'b00);
      default:         misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] fmt_read(input logic [1:0] t, input logic sgn,
                                           input logic [63:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [63:0] ext;
    b   = raw[7:0];
    h   = raw[15:0];
    ext = raw;
    case (t)
      T_BYTE:  if (sgn) ext = 64'(b); else ext = {56'd0, raw[7:0]};
      T_HALF:  if (sgn) ext = 64'(h); else ext = {48'd0, raw[15:0]};
      T_WORD:  ext = {32'd0, raw[31:0]};
      default: ext = raw;
    endcase
    fmt_read = ext;
  endfunction

  // MOC is asynchronous to clk: two-flop synchroniser, only moc_s is used
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      moc_p0 <= 1'b0;
      moc_p1 <= 1'b0;
    end else begin
      moc_p0 <= bus.mem_moc;
      moc_p1 <= moc_p0;
    end
  end

  assign moc_s = moc_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      beat_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      en_q     <= 1'b0;
      mrw_q    <= 1'b0;
      mtype_q  <= 2'b00;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      en_q     <= en_d;
      mrw_q    <= mrw_d;
      mtype_q  <= mtype_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Latched request fields are only consumed after acceptance
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    sgn_q   <= sgn_d;
    type_q  <= type_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    sgn_d    = sgn_q;
    type_d   = type_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    en_d     = en_q;
    mrw_d    = mrw_q;
    mtype_d  = mtype_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          rw_d    = bus.req_rw;
          sgn_d   = bus.req_signed;
          type_d  = bus.req_type;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          busy_d  = 1'b1;
          beat_d  = 1'b0;
          err_d   = 1'b0;
          if (misaligned(bus.req_type, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            mrw_d    = bus.req_rw;
            mtype_d  = (bus.req_type == T_DWORD) ? T_WORD : bus.req_type;
            maddr_d  = bus.req_addr;
            mwdata_d = (bus.req_type == T_DWORD) ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
            state_d  = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (moc_s) begin
          if (rw_q) begin
            if (type_q == T_DWORD && !beat_q) rdata_d[63:32] = bus.mem_rdata;
            else                              rdata_d[31:0]  = bus.mem_rdata;
          end
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        if (!moc_s) begin
          if (type_q == T_DWORD && !beat_q) begin
            beat_d   = 1'b1;
            maddr_d  = addr_q + ADDR_W'(4);
            mwdata_d = wdata_q[31:0];
            state_d  = S_SETUP;
          end else begin
            if (rw_q) rdata_d = fmt_read(type_q, sgn_q, rdata_q);
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_enable = en_q;
  assign bus.mem_rw     = mrw_q;
  assign bus.mem_type   = mtype_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_wdata  = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a byte-array RAM with random MOC delays answers the
// handshake; a transaction-level reference memory supplies every expected value.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_access_ctrl_if #(.ADDR_W(32)) bus ();

  mem_access_ctrl #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram  [256];
  logic [7:0]  refm [256];
  logic [7:0]  img  [256];
  bit          load_img = 1'b1;
  bit          tie_low  = 1'b0;
  int          dly;
  logic [7:0]  ma;
  logic        en_prev;
  int          en_rises = 0;
  int          en_cycles = 0;
  int          done_cnt = 0;
  logic [31:0] en_addrs [$];

  // RAM: answers Enable after 0..2 cycles, drops MOC 0..2 cycles after Enable falls
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_moc   <= 1'b0;
      bus.mem_rdata <= '0;
      dly           <= 0;
      if (load_img) for (int i = 0; i < 256; i++) ram[i] = img[i];
    end else if (!bus.mem_moc) begin
      if (bus.mem_enable && !tie_low) begin
        if (dly > 0) dly <= dly - 1;
        else begin
          ma = bus.mem_addr[7:0];
          if (bus.mem_rw) begin
            case (bus.mem_type)
              2'b00:   bus.mem_rdata <= {24'd0, ram[ma]};
              2'b01:   bus.mem_rdata <= {16'd0, ram[ma], ram[ma+8'd1]};
              default: bus.mem_rdata <= {ram[ma], ram[ma+8'd1], ram[ma+8'd2], ram[ma+8'd3]};
            endcase
          end else begin
            case (bus.mem_type)
              2'b00: ram[ma] = bus.mem_wdata[7:0];
              2'b01: begin
                ram[ma]      = bus.mem_wdata[15:8];
                ram[ma+8'd1] = bus.mem_wdata[7:0];
              end
              default: begin
                ram[ma]      = bus.mem_wdata[31:24];
                ram[ma+8'd1] = bus.mem_wdata[23:16];
                ram[ma+8'd2] = bus.mem_wdata[15:8];
                ram[ma+8'd3] = bus.mem_wdata[7:0];
              end
            endcase
          end
          bus.mem_moc <= 1'b1;
          dly         <= $urandom_range(0, 2);
        end
      end
    end else if (!bus.mem_enable) begin
      if (dly > 0) dly <= dly - 1;
      else begin
        bus.mem_moc <= 1'b0;
        dly         <= $urandom_range(0, 2);
      end
    end
  end

  always @(posedge clk) begin
    en_prev <= bus.mem_enable;
    if (bus.mem_enable === 1'b1) begin
      en_cycles++;
      if (en_prev !== 1'b1) begin
        en_rises++;
        en_addrs.push_back(bus.mem_addr);
      end
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  function automatic logic [63:0] ref_read(input logic [1:0] t, input logic sg,
                                           input logic [31:0] a);
    int          n = 1 << t;
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], refm[8'(a + 32'(i))]};
    if (sg && t == 2'b00 && v[7])  v[63:8]  = '1;
    if (sg && t == 2'b01 && v[15]) v[63:16] = '1;
    return v;
  endfunction

  task automatic ref_write(input logic [1:0] t, input logic [31:0] a, input logic [63:0] wd);
    int n = 1 << t;
    for (int i = 0; i < n; i++) refm[8'(a + 32'(i))] = wd[8*(n-1-i) +: 8];
  endtask

  function automatic logic ref_mis(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'b00) return 1'b0;
    if (t == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  task automatic do_req(input logic rw, input logic [1:0] t, input logic sg,
                        input logic [31:0] a, input logic [63:0] wd,
                        output logic e, output logic [63:0] rd, output int lat,
                        output logic en_at_done);
    @(negedge clk);
    bus.req = 1'b1; bus.req_rw = rw; bus.req_type = t;
    bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b need 1", bus.busy);
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat <= 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat > 200) begin
      errors++;
      $display("FAIL done_timeout: no done within 200 cycles (addr %h type %b)", a, t);
    end
    e = bus.err; rd = bus.rdata; en_at_done = bus.mem_enable;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle: done,busy=%b%b need 00", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done, bus.err, bus.mem_enable, bus.mem_rw} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b need 00000",
               {bus.busy, bus.done, bus.err, bus.mem_enable, bus.mem_rw});
    end
    checks++;
    if ({bus.mem_type, bus.mem_addr, bus.mem_wdata} !== 66'd0) begin
      errors++;
      $display("FAIL reset_bus: type %b addr %h wdata %h need zeros",
               bus.mem_type, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (bus.rdata !== 64'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h need 0", bus.rdata);
    end
  endtask

  task automatic test_word_read();
    logic e, ed; logic [63:0] rd; int lat, n0, d0;
    n0 = en_rises; d0 = done_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 64'd0, e, rd, lat, ed);
    @(posedge clk); #1;
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL word_err: got %b need 0", e); end
    checks++;
    if (rd !== 64'h0000_0000_1234_5678) begin
      errors++; $display("FAIL word_rdata: got %h need 0000000012345678", rd);
    end
    checks++;
    if (en_rises - n0 != 1) begin
      errors++; $display("FAIL word_enable_pulses: got %0d need 1", en_rises - n0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL word_done_count: got %0d need 1", done_cnt - d0);
    end
    checks++;
    if (lat < 7) begin errors++; $display("FAIL word_latency: got %0d need >=7", lat); end
  endtask

  task automatic test_byte_sign();
    logic e, ed; logic [63:0] rd; int lat;
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 64'h9A, e, rd, lat, ed);
    ref_write(2'b00, 32'h10, 64'h9A);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL byte_write_err: got %b need 0", e); end
    do_req(1'b1, 2'b00, 1'b1, 32'h10, 64'd0, e, rd, lat, ed);
    checks++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FF9A) begin
      errors++; $display("FAIL byte_signed: got %h need ffffffffffffff9a", rd);
    end
    do_req(1'b1, 2'b00, 1'b0, 32'h10, 64'd0, e, rd, lat, ed);
    checks++;
    if (rd !== 64'h0000_0000_0000_009A) begin
      errors++; $display("FAIL byte_unsigned: got %h need 000000000000009a", rd);
    end
    do_req(1'b1, 2'b01, 1'b1, 32'h10, 64'd0, e, rd, lat, ed);
    checks++;
    if (rd !== ref_read(2'b01, 1'b1, 32'h10)) begin
      errors++; $display("FAIL half_signed: got %h need %h", rd, ref_read(2'b01, 1'b1, 32'h10));
    end
  endtask

  task automatic test_double();
    logic e, ed; logic [63:0] rd; int lat, n0, bad;
    for (int pass = 0; pass < 2; pass++) begin
      n0 = en_rises;
      do_req(pass == 1, 2'b11, 1'b0, 32'h20, 64'h1122334455667788, e, rd, lat, ed);
      if (pass == 0) ref_write(2'b11, 32'h20, 64'h1122334455667788);
      @(posedge clk); #1;
      checks++;
      if (en_rises - n0 != 2 || en_addrs[n0] !== 32'h20 || en_addrs[n0+1] !== 32'h24) begin
        errors++;
        $display("FAIL dword_beats pass %0d: pulses %0d addrs %h %h need 2 at 20 24",
                 pass, en_rises - n0, en_addrs[n0], en_addrs[n0+1]);
      end
      if (pass == 0) begin
        bad = 0;
        for (int i = 0; i < 8; i++) if (ram[8'h20 + i] !== 8'(8'h11 * (i + 1))) bad++;
        checks++;
        if (bad != 0) begin
          errors++; $display("FAIL dword_write_ram: %0d bytes wrong in 20..27, need 11..88", bad);
        end
      end else begin
        checks++;
        if (rd !== 64'h1122334455667788) begin
          errors++; $display("FAIL dword_read: got %h need 1122334455667788", rd);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    logic e, ed; logic [63:0] rd; int lat, n0;
    n0 = en_rises;
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 64'd0, e, rd, lat, ed);
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 64'hDEAD, e, rd, lat, ed);
    checks++;
    if (e !== 1'b1 || lat != 0) begin
      errors++; $display("FAIL misaligned: err %b lat %0d need err 1 lat 0", e, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (en_rises != n0) begin
      errors++; $display("FAIL misaligned_enable: got %0d pulses need 0", en_rises - n0);
    end
  endtask

  task automatic test_timeout();
    logic e, ed; logic [63:0] rd; int lat, c0;
    tie_low = 1'b1;
    c0 = en_cycles;
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 64'd0, e, rd, lat, ed);
    tie_low = 1'b0;
    checks++;
    if (e !== 1'b1 || ed !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err %b enable %b need 1 0", e, ed);
    end
    checks++;
    if (en_cycles - c0 != 8 || lat != 9) begin
      errors++;
      $display("FAIL timeout_len: access %0d lat %0d need 8 9", en_cycles - c0, lat);
    end
  endtask

  task automatic test_random();
    logic e, ed, rw, sg, mis, rd_known; logic [1:0] t; logic [31:0] a;
    logic [63:0] wd, rd, exp_rd; int lat, n0, exp_n, bad;
    rd_known = 1'b0; exp_rd = '0;
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1)); t = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1)); a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h7;
      wd = {$urandom, $urandom};
      mis = ref_mis(t, a);
      exp_n = mis ? 0 : ((t == 2'b11) ? 2 : 1);
      if (rw && !mis) exp_rd = ref_read(t, sg, a);
      n0 = en_rises;
      do_req(rw, t, sg, a, wd, e, rd, lat, ed);
      @(posedge clk); #1;
      checks++;
      if (e !== mis || en_rises - n0 != exp_n) begin
        errors++;
        $display("FAIL rand_err_beats #%0d: err %b pulses %0d need %b %0d (t %b a %h)",
                 k, e, en_rises - n0, mis, exp_n, t, a);
      end
      if (rw && !mis) begin
        checks++;
        if (rd !== exp_rd) begin
          errors++; $display("FAIL rand_rdata #%0d: got %h need %h (t %b a %h)", k, rd, exp_rd, t, a);
        end
        rd_known = 1'b1;
      end else if (rw) begin
        rd_known = 1'b0;
      end else begin
        if (!mis) ref_write(t, a, wd);
        if (rd_known) begin
          checks++;
          if (rd !== exp_rd) begin
            errors++; $display("FAIL rand_rdata_held #%0d: got %h need %h", k, rd, exp_rd);
          end
        end
      end
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== refm[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_ram_image: %0d bytes differ need 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic e, ed; logic [63:0] rd; int lat, w, d0;
    @(negedge clk);
    bus.req = 1'b1; bus.req_rw = 1'b1; bus.req_type = 2'b10;
    bus.req_signed = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = '0;
    @(negedge clk);
    bus.req = 1'b0;
    w = 0;
    while (bus.mem_enable !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    checks++;
    if (w >= 20) begin errors++; $display("FAIL rstmid_no_access: enable never rose"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_enable, bus.busy, bus.done} !== 3'b000 || bus.mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: en,busy,done=%b%b%b addr %h need 000 0",
               bus.mem_enable, bus.busy, bus.done, bus.mem_addr);
    end
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != d0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_dropped: done pulses %0d busy %b need 0 0", done_cnt - d0, bus.busy);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 64'd0, e, rd, lat, ed);
    checks++;
    if (e !== 1'b0 || rd !== ref_read(2'b10, 1'b0, 32'h10)) begin
      errors++;
      $display("FAIL rstmid_fresh: err %b rdata %h need 0 %h", e, rd, ref_read(2'b10, 1'b0, 32'h10));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req = 1'b0; bus.req_rw = 1'b0; bus.req_type = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[8'h10] = 8'h12; img[8'h11] = 8'h34; img[8'h12] = 8'h56; img[8'h13] = 8'h78;
    for (int i = 0; i < 256; i++) refm[i] = img[i];
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load_img = 1'b0;
    repeat (3) @(negedge clk);
    test_word_read();
    test_byte_sign();
    test_double();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
